// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access controller: MAR/MDR registers and a req/ack handshake
// with variable memory latency, R (ready) signalling and a timeout guard.
module lc3_mem_ctrl #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] bus_i,
    input  logic          ld_mar,
    input  logic          ld_mdr,
    input  logic          mio_en,
    input  logic          r_w,
    output logic [AW-1:0] mar_o,
    output logic [DW-1:0] mdr_o,
    output logic          ready_o,
    output logic          err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] mar_q;
    logic [DW-1:0] mdr_q;
    logic [CW-1:0] cnt_q;
    logic          rw_q;
    logic          ready_q;
    logic          err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Loads on the start edge still land, so the access sees them.
                    if (ld_mar) mar_q <= bus_i[AW-1:0];
                    if (ld_mdr) mdr_q <= bus_i;
                    if (mio_en) begin
                        state <= WAIT;
                        rw_q  <= r_w;
                        err_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                WAIT: begin
                    // Ack takes priority over an expiring timeout on the same edge.
                    if (mem_ack_i) begin
                        if (!rw_q) mdr_q <= mem_rdata_i;
                        state   <= DONE;
                        ready_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state   <= DONE;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    // Hold R until MIO.EN drops so the microsequencer cannot re-trigger.
                    if (!mio_en) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign mar_o       = mar_q;
    assign mdr_o       = mdr_q;
    assign ready_o     = ready_q;
    assign err_o       = err_q;
    assign mem_addr_o  = mar_q;
    assign mem_wdata_o = mdr_q;
    // Decoded from state so that an async reset drops the request at once.
    assign mem_req_o   = (state == WAIT);
    assign mem_we_o    = (state == WAIT) && rw_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed self-checking bench for lc3_mem_ctrl (TIMEOUT=4).
module tb_lc3_mem_ctrl;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] bus_i;
    logic          ld_mar;
    logic          ld_mdr;
    logic          mio_en;
    logic          r_w;
    logic [AW-1:0] mar_o;
    logic [DW-1:0] mdr_o;
    logic          ready_o;
    logic          err_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ack_i;

    int errs   = 0;
    int checks = 0;

    lc3_mem_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_i      (bus_i),
        .ld_mar     (ld_mar),
        .ld_mdr     (ld_mdr),
        .mio_en     (mio_en),
        .r_w        (r_w),
        .mar_o      (mar_o),
        .mdr_o      (mdr_o),
        .ready_o    (ready_o),
        .err_o      (err_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; bus_i = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
        mem_rdata_i = '0; mem_ack_i = 0;
        #12;
        chk("rst_mar", 32'(mar_o), 32'h0);
        chk("rst_mdr", 32'(mdr_o), 32'h0);
        chk("rst_ready", 32'(ready_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_req", 32'(mem_req_o), 32'h0);
        chk("rst_we", 32'(mem_we_o), 32'h0);
        rst_n = 1'b1;
        step();

        // load MAR in IDLE
        ld_mar = 1; bus_i = 16'h3000;
        step();
        ld_mar = 0;
        chk("ld_mar", 32'(mar_o), 32'h3000);
        chk("ld_mar_mdr", 32'(mdr_o), 32'h0);
        chk("ld_mar_req", 32'(mem_req_o), 32'h0);

        // zero-wait read
        mio_en = 1; r_w = 0;
        step();
        chk("zw_req", 32'(mem_req_o), 32'h1);
        chk("zw_we", 32'(mem_we_o), 32'h0);
        chk("zw_addr", 32'(mem_addr_o), 32'h3000);
        chk("zw_ready_early", 32'(ready_o), 32'h0);
        mem_ack_i = 1; mem_rdata_i = 16'hABCD;
        step();
        mem_ack_i = 0;
        chk("zw_req_off", 32'(mem_req_o), 32'h0);
        chk("zw_mdr", 32'(mdr_o), 32'hABCD);
        chk("zw_ready", 32'(ready_o), 32'h1);
        step();
        chk("zw_ready_hold", 32'(ready_o), 32'h1);
        chk("zw_req_hold", 32'(mem_req_o), 32'h0);
        mio_en = 0;
        step();
        chk("zw_ready_clr", 32'(ready_o), 32'h0);

        // wait-state write, ld_mdr ignored during WAIT
        ld_mar = 1; bus_i = 16'h4000;
        step();
        ld_mar = 0; ld_mdr = 1; bus_i = 16'h1234;
        step();
        ld_mdr = 0;
        mio_en = 1; r_w = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("wr_req", 32'(mem_req_o), 32'h1);
            chk("wr_we", 32'(mem_we_o), 32'h1);
            chk("wr_addr", 32'(mem_addr_o), 32'h4000);
            chk("wr_wdata", 32'(mem_wdata_o), 32'h1234);
            ld_mdr = (i < 3); bus_i = 16'hFFFF;
            mem_ack_i = (i == 3);
            step();
        end
        ld_mdr = 0; mem_ack_i = 0;
        chk("wr_ready", 32'(ready_o), 32'h1);
        chk("wr_err", 32'(err_o), 32'h0);
        chk("wr_mdr", 32'(mdr_o), 32'h1234);
        chk("wr_req_off", 32'(mem_req_o), 32'h0);
        mio_en = 0;
        step();

        // timeout: no ack
        mio_en = 1; r_w = 0; mem_rdata_i = 16'h7777;
        step();
        for (int i = 0; i < TO; i++) begin
            chk("to_req", 32'(mem_req_o), 32'h1);
            step();
        end
        chk("to_req_off", 32'(mem_req_o), 32'h0);
        chk("to_ready", 32'(ready_o), 32'h1);
        chk("to_err", 32'(err_o), 32'h1);
        chk("to_mdr", 32'(mdr_o), 32'h1234);
        mio_en = 0;
        step();
        chk("to_err_hold", 32'(err_o), 32'h1);
        chk("to_ready_clr", 32'(ready_o), 32'h0);

        // start with ld_mar on the same edge; err clears; ack on timeout edge
        ld_mar = 1; bus_i = 16'h5000; mio_en = 1; r_w = 0;
        step();
        ld_mar = 0;
        chk("st_addr", 32'(mem_addr_o), 32'h5000);
        chk("st_err_clr", 32'(err_o), 32'h0);
        chk("st_req", 32'(mem_req_o), 32'h1);
        step(); step(); step();
        chk("tb_req", 32'(mem_req_o), 32'h1);
        mem_ack_i = 1; mem_rdata_i = 16'h5A5A;
        step();
        mem_ack_i = 0;
        chk("tb_err", 32'(err_o), 32'h0);
        chk("tb_mdr", 32'(mdr_o), 32'h5A5A);
        chk("tb_ready", 32'(ready_o), 32'h1);
        mio_en = 0;
        step();

        // stray ack in IDLE
        mem_ack_i = 1; mem_rdata_i = 16'hDEAD;
        step(); step();
        mem_ack_i = 0;
        chk("stray_mdr", 32'(mdr_o), 32'h5A5A);
        chk("stray_ready", 32'(ready_o), 32'h0);
        chk("stray_req", 32'(mem_req_o), 32'h0);

        // reset during a stalled read
        mio_en = 1; r_w = 0;
        step();
        step();
        chk("mr_req", 32'(mem_req_o), 32'h1);
        #2;
        rst_n = 0; mio_en = 0;
        #1;
        chk("mr_req_drop", 32'(mem_req_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
        mem_ack_i = 1; mem_rdata_i = 16'hBEEF;
        step(); step();
        mem_ack_i = 0;
        chk("mr_mdr", 32'(mdr_o), 32'h0);
        chk("mr_ready", 32'(ready_o), 32'h0);
        chk("mr_req_idle", 32'(mem_req_o), 32'h0);
        chk("mr_mar", 32'(mar_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory-access controller between the LC-3 datapath and the memory subsystem. It holds the MAR and MDR registers, turns the microsequencer's MIO.EN/R.W request into a req/ack transaction with variable latency, and returns the R (ready) signal. The microsequencer loops on R; memory may stall arbitrarily, and a timeout guard stops a missing ack from hanging the core.

## Interface
- AW, 16, address width (MAR).
- DW, 16, data width (MDR, bus).
- TIMEOUT, 255, cycles in WAIT without ack before abort; must be ≥1.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bus_i  in  DW  datapath bus; source for MAR/MDR loads.
- ld_mar  in  1  load MAR from bus_i[AW-1:0].
- ld_mdr  in  1  load MDR from bus_i.
- mio_en  in  1  memory access request (level).
- r_w  in  1  1 = write, 0 = read; sampled when an access starts.
- mar_o  out  AW  MAR contents.
- mdr_o  out  DW  MDR contents.
- ready_o  out  1  R signal: access complete.
- err_o  out  1  last access timed out.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  write enable, valid while mem_req_o=1.
- mem_addr_o  out  AW  equals MAR.
- mem_wdata_o  out  DW  equals MDR.
- mem_rdata_i  in  DW  read data, valid when mem_ack_i=1.
- mem_ack_i  in  1  completion; honoured only while mem_req_o=1.

## Operation
- States: IDLE, WAIT, DONE. All state is in flops. All outputs come from registers, except mem_req_o and mem_we_o, which are decoded from state and the latched r_w.
- IDLE:
  - ld_mar and ld_mdr load on the clock edge.
  - mio_en=1 at an edge: latch r_w, clear err_o and the timeout counter, go to WAIT.
  - ld_mar/ld_mdr asserted on the same start edge still load. The access then uses the new MAR/MDR.
- WAIT:
  - mem_req_o=1; mem_we_o = latched r_w.
  - mem_addr_o and mem_wdata_o are held stable, because ld_mar and ld_mdr are ignored outside IDLE.
  - Edge with mem_ack_i=1: a read captures mem_rdata_i into MDR, a write leaves MDR unchanged. Go to DONE.
  - No ack: the counter increments. When the counter reaches TIMEOUT-1 without ack, go to DONE, set err_o=1, and leave MDR unchanged.
  - Ack on the same edge as timeout: ack wins and err_o stays 0.
  - mio_en dropping in WAIT does not cancel the access.
- DONE:
  - ready_o=1, mem_req_o=0.
  - Stays in DONE while mio_en=1. Goes to IDLE on the first edge with mio_en=0.
  - This makes the level handshake with the microsequencer loop safe: no re-trigger while MIO.EN is still high.
- err_o holds its value until the next access start or reset.
- mem_ack_i outside WAIT is ignored.

## Timing
- Reset (async, immediate): state=IDLE, MAR=0, MDR=0, counter=0. ready_o, err_o, mem_req_o, mem_we_o all 0.
- Reset mid-access: mem_req_o drops asynchronously. A later ack is ignored.
- Read/write timing:
  - mio_en sampled at edge k (IDLE): mem_req_o high from k+ through the ack edge.
  - Zero-wait memory (ack in the first WAIT cycle): MDR updated and ready_o=1 after edge k+1, i.e. 2-cycle access.
  - N wait cycles: ready_o rises after edge k+1+N.
- Timeout: ready_o=1 and err_o=1 after edge k+TIMEOUT. mem_req_o is high for exactly TIMEOUT cycles.
- After DONE → IDLE, a new access can start on the next edge: minimum 1 idle cycle between accesses.
- Loads in IDLE: mar_o/mdr_o update the cycle after the ld edge.

## Test plan
- Reset then idle: all outputs 0. ld_mar with bus_i=0x3000 → mar_o=0x3000, mdr_o=0, mem_req_o=0.
- Zero-wait read: MAR=0x3000, memory acks immediately with 0xABCD → mem_req_o high 1 cycle, mem_we_o=0, mdr_o=0xABCD, ready_o=1 two cycles after mio_en sampled. ready_o stays high while mio_en=1 and clears one cycle after mio_en=0.
- Wait-state write: MAR=0x4000, MDR=0x1234, r_w=1, ack after 3 wait cycles → mem_addr_o=0x4000 and mem_wdata_o=0x1234 stable for 4 req cycles. ld_mdr with bus_i=0xFFFF during WAIT is ignored, and mdr_o stays 0x1234.
- Timeout with TIMEOUT=4 and no ack → mem_req_o high exactly 4 cycles, then ready_o=1, err_o=1, MDR unchanged. The next successful access clears err_o at its start.
- Boundaries:
  - Ack on the timeout cycle → err_o=0 and read data captured.
  - ld_mar with bus_i=0x5000 on the same edge as the mio_en start → mem_addr_o=0x5000.
  - Stray ack in IDLE → no effect.
- Reset mid-WAIT (rst_n low for 1 cycle during a stalled read) → mem_req_o drops immediately. A subsequent ack leaves mdr_o=0 and ready_o=0.
